// File: rtl/vec_wb_if.sv
// Producer-side result handshake and register-file write port of the writeback queue.
interface vec_wb_if #(
  parameter int unsigned LANES = 16,
  parameter int unsigned DW    = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_rd;
  logic                  in_vec;
  logic [2:0]            in_cmd;
  logic [LANES*DW-1:0]   in_data;
  logic                  we3;
  logic [3:0]            ra3;
  logic [LANES*DW-1:0]   wd3;
  logic                  selec_v_s_w;
  logic [2:0]            cmd;

  modport master (
    output in_valid, in_rd, in_vec, in_cmd, in_data,
    input  in_ready, we3, ra3, wd3, selec_v_s_w, cmd
  );

  modport slave (
    input  in_valid, in_rd, in_vec, in_cmd, in_data,
    output in_ready, we3, ra3, wd3, selec_v_s_w, cmd
  );
endinterface

// File: rtl/vec_wb_queue.sv
// Writeback FIFO feeding the vector/scalar register-file write port, one write per cycle,
// with read-after-write hazard detection for the decode-stage read addresses.
module vec_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LANES = 16,
  parameter int unsigned DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  vec_wb_if.slave                      wb,
  input  logic                         flush,
  input  logic                         wb_hold,
  input  logic [3:0]                   chk_ra1,
  input  logic [3:0]                   chk_ra2,
  input  logic                         chk_vs,
  output logic                         hazard1,
  output logic                         hazard2,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err_drop
);
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = $clog2(DEPTH+1);
  localparam int unsigned DATA_W = LANES * DW;

  typedef struct packed {
    logic [3:0]        rd;
    logic              vec;
    logic [2:0]        cmd;
    logic              tgt_vec;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            out_tgt_vec;

  logic            tgt_vec_in;
  logic            illegal;
  logic            push;
  logic            enq;
  logic            pop;

  // cmd 3'b101 always writes the scalar file; scalar r15 is the PC and must never be written
  assign tgt_vec_in  = wb.in_vec && (wb.in_cmd != 3'b101);
  assign illegal     = !tgt_vec_in && (wb.in_rd == 4'hF);
  assign wb.in_ready = (count < CW'(DEPTH));
  assign push        = wb.in_valid && wb.in_ready && !flush;
  assign enq         = push && !illegal;
  assign pop         = !flush && !wb_hold && (count != '0);

  // Entry storage needs no reset; validity comes from head/count
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= '{rd: wb.in_rd, vec: wb.in_vec, cmd: wb.in_cmd,
                     tgt_vec: tgt_vec_in, data: wb.in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      wb.we3         <= 1'b0;
      wb.ra3         <= '0;
      wb.wd3         <= '0;
      wb.selec_v_s_w <= 1'b0;
      wb.cmd         <= '0;
      out_tgt_vec    <= 1'b0;
    end else if (flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wb.we3 <= 1'b0;
    end else begin
      if (enq) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head           <= head + PW'(1);
        wb.we3         <= 1'b1;
        wb.ra3         <= mem[head].rd;
        wb.wd3         <= mem[head].data;
        wb.selec_v_s_w <= mem[head].vec;
        wb.cmd         <= mem[head].cmd;
        out_tgt_vec    <= mem[head].tgt_vec;
      end else begin
        wb.we3 <= 1'b0;
      end
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_drop <= 1'b0;
    end else if (push && illegal) begin
      err_drop <= 1'b1;
    end
  end

  // A write is pending if it sits in a valid slot or in the output stage this cycle
  logic [PW-1:0] offs;
  logic          hz1;
  logic          hz2;
  always_comb begin
    hz1  = 1'b0;
    hz2  = 1'b0;
    offs = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head;
      if ((CW'(offs) < count) && (mem[i].tgt_vec == chk_vs)) begin
        if (mem[i].rd == chk_ra1) hz1 = 1'b1;
        if (mem[i].rd == chk_ra2) hz2 = 1'b1;
      end
    end
    if (wb.we3 && (out_tgt_vec == chk_vs)) begin
      if (wb.ra3 == chk_ra1) hz1 = 1'b1;
      if (wb.ra3 == chk_ra2) hz2 = 1'b1;
    end
    if (!chk_vs && (chk_ra1 == 4'hF)) hz1 = 1'b0;
    if (!chk_vs && (chk_ra2 == 4'hF)) hz2 = 1'b0;
  end

  assign hazard1 = hz1;
  assign hazard2 = hz2;
endmodule

// File: tb/tb_vec_wb_queue.sv
// Directed and randomized bench for vec_wb_queue against a queue-based reference model.
module tb_vec_wb_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LANES = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DATAW = LANES * DW;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wb_hold;
  logic [3:0] chk_ra1;
  logic [3:0] chk_ra2;
  logic       chk_vs;
  logic       hazard1;
  logic       hazard2;
  logic [2:0] count;
  logic       err_drop;

  int total = 0;
  int bad   = 0;

  vec_wb_if #(.LANES(LANES), .DW(DW)) bus ();

  vec_wb_queue #(.DEPTH(DEPTH), .LANES(LANES), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wb(bus.slave), .flush(flush), .wb_hold(wb_hold),
    .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_vs(chk_vs),
    .hazard1(hazard1), .hazard2(hazard2), .count(count), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       rd;
    logic             vec;
    logic [2:0]       cmd;
    logic [DATAW-1:0] data;
    logic             tgt;
  } ent_t;

  ent_t             q[$];
  logic             m_we, m_sel, m_tgt, m_err;
  logic [3:0]       m_ra;
  logic [2:0]       m_cmd;
  logic [DATAW-1:0] m_wd;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_sel = 1'b0; m_tgt = 1'b0; m_err = 1'b0;
    m_ra = '0; m_cmd = '0; m_wd = '0;
  endtask

  function automatic logic hz_model(input logic [3:0] ra, input logic vs);
    logic h = 1'b0;
    foreach (q[i]) if (q[i].rd == ra && q[i].tgt == vs) h = 1'b1;
    if (m_we && m_ra == ra && m_tgt == vs) h = 1'b1;
    return h;
  endfunction

  task automatic drive(input logic v, input logic [3:0] rd, input logic vec,
                       input logic [2:0] c, input logic [31:0] lane15);
    bus.in_valid = v;
    bus.in_rd    = rd;
    bus.in_vec   = vec;
    bus.in_cmd   = c;
    bus.in_data  = '0;
    bus.in_data[DATAW-1 -: 32] = lane15;
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registered outputs
  task automatic cycle();
    logic do_pop, do_push, tgt;
    ent_t e;
    #1;
    chk("in_ready", 512'(bus.in_ready), 512'(q.size() < DEPTH));
    chk("count_pre", 512'(count), 512'(q.size()));
    chk("hazard1", 512'(hazard1), 512'(hz_model(chk_ra1, chk_vs)));
    chk("hazard2", 512'(hazard2), 512'(hz_model(chk_ra2, chk_vs)));
    @(posedge clk);
    if (flush) begin
      q.delete();
      m_we = 1'b0;
    end else begin
      do_pop  = !wb_hold && q.size() > 0;
      do_push = bus.in_valid && q.size() < DEPTH;
      if (do_pop) begin
        e = q.pop_front();
        m_we = 1'b1; m_ra = e.rd; m_wd = e.data; m_sel = e.vec; m_cmd = e.cmd; m_tgt = e.tgt;
      end else begin
        m_we = 1'b0;
      end
      if (do_push) begin
        tgt = bus.in_vec && bus.in_cmd != 3'b101;
        if (!tgt && bus.in_rd == 4'hF) m_err = 1'b1;
        else q.push_back('{rd: bus.in_rd, vec: bus.in_vec, cmd: bus.in_cmd,
                           data: bus.in_data, tgt: tgt});
      end
    end
    #1;
    chk("we3", 512'(bus.we3), 512'(m_we));
    chk("count", 512'(count), 512'(q.size()));
    chk("err_drop", 512'(err_drop), 512'(m_err));
    if (m_we) begin
      chk("ra3", 512'(bus.ra3), 512'(m_ra));
      chk("wd3", 512'(bus.wd3), 512'(m_wd));
      chk("selec_v_s_w", 512'(bus.selec_v_s_w), 512'(m_sel));
      chk("cmd", 512'(bus.cmd), 512'(m_cmd));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_hold = 1'b0;
    chk_ra1 = '0; chk_ra2 = '0; chk_vs = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 3'd0, 32'd0);
    model_reset();
    @(posedge clk); #1;
    chk("rst_we3", 512'(bus.we3), 512'(0));
    chk("rst_count", 512'(count), 512'(0));
    chk("rst_ready", 512'(bus.in_ready), 512'(1));
    chk("rst_ra3", 512'(bus.ra3), 512'(0));
    chk("rst_wd3", 512'(bus.wd3), 512'(0));
    chk("rst_err", 512'(err_drop), 512'(0));
    rst = 1'b0;

    // Single scalar write into an empty queue
    drive(1'b1, 4'd3, 1'b0, 3'd0, 32'h2A); cycle();
    chk("t1_we3_lat", 512'(bus.we3), 512'(0));
    drive(1'b0, 4'd0, 1'b0, 3'd0, 32'd0); cycle();
    chk("t1_we3", 512'(bus.we3), 512'(1));
    chk("t1_ra3", 512'(bus.ra3), 512'(3));
    chk("t1_sel", 512'(bus.selec_v_s_w), 512'(0));
    chk("t1_lane15", 512'(bus.wd3[DATAW-1 -: 32]), 512'(32'h2A));
    cycle();
    chk("t1_we3_off", 512'(bus.we3), 512'(0));
    chk("t1_count", 512'(count), 512'(0));

    // Fill and back-pressure
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 1'b1, 3'd0, 32'(i)); cycle();
    end
    chk("fill_count", 512'(count), 512'(4));
    chk("fill_ready", 512'(bus.in_ready), 512'(0));
    drive(1'b1, 4'd9, 1'b1, 3'd0, 32'd9); cycle();
    chk("fill_5th", 512'(count), 512'(4));
    wb_hold = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 3'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk("drain_we3", 512'(bus.we3), 512'(1));
      chk("drain_ra3", 512'(bus.ra3), 512'(i));
    end
    cycle();
    chk("drain_end", 512'(bus.we3), 512'(0));

    // Hazards on vector r5 and scalar r5 (vector opcode with cmd 101)
    wb_hold = 1'b1;
    drive(1'b1, 4'd5, 1'b1, 3'd0, 32'h55); cycle();
    drive(1'b1, 4'd5, 1'b1, 3'b101, 32'h66); cycle();
    drive(1'b0, 4'd0, 1'b0, 3'd0, 32'd0);
    chk_vs = 1'b1; chk_ra1 = 4'd5; chk_ra2 = 4'd0; #1;
    chk("hz_vec", 512'(hazard1), 512'(1));
    chk_vs = 1'b0; chk_ra1 = 4'd0; chk_ra2 = 4'd5; #1;
    chk("hz_scl", 512'(hazard2), 512'(1));
    wb_hold = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("hz_clr2", 512'(hazard2), 512'(0));
    chk_vs = 1'b1; chk_ra1 = 4'd5; #1;
    chk("hz_clr1", 512'(hazard1), 512'(0));

    // Illegal scalar r15 write is dropped
    drive(1'b1, 4'hF, 1'b0, 3'd0, 32'hDEAD); cycle();
    chk("ill_count", 512'(count), 512'(0));
    chk("ill_err", 512'(err_drop), 512'(1));
    drive(1'b0, 4'd0, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("ill_we3", 512'(bus.we3), 512'(0));
    end
    chk_vs = 1'b0; chk_ra1 = 4'hF; #1;
    chk("ill_hz_pc", 512'(hazard1), 512'(0));
    chk("ill_sticky", 512'(err_drop), 512'(1));

    // Flush with a simultaneous push
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 1), 1'b1, 3'd1, 32'(i)); cycle();
    end
    chk("fl_count3", 512'(count), 512'(3));
    flush = 1'b1;
    drive(1'b1, 4'd7, 1'b1, 3'd0, 32'd7); cycle();
    chk("fl_count", 512'(count), 512'(0));
    chk("fl_we3", 512'(bus.we3), 512'(0));
    flush = 1'b0; wb_hold = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_nowrite", 512'(bus.we3), 512'(0));
    end

    // Asynchronous reset mid-drain
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 8), 1'b1, 3'd2, 32'(i)); cycle();
    end
    wb_hold = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 3'd0, 32'd0); cycle();
    chk("ar_we3_pre", 512'(bus.we3), 512'(1));
    chk("ar_count_pre", 512'(count), 512'(2));
    rst = 1'b1; #1;
    chk("ar_we3", 512'(bus.we3), 512'(0));
    chk("ar_count", 512'(count), 512'(0));
    chk("ar_ready", 512'(bus.in_ready), 512'(1));
    model_reset();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("ar_nowrite", 512'(bus.we3), 512'(0));
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      bus.in_valid = 1'($urandom_range(0, 99) < 60);
      bus.in_rd    = 4'($urandom());
      bus.in_vec   = 1'($urandom());
      bus.in_cmd   = 3'($urandom());
      for (int l = 0; l < LANES; l++) bus.in_data[l*DW +: DW] = $urandom();
      wb_hold = 1'($urandom_range(0, 99) < 30);
      flush   = 1'($urandom_range(0, 99) < 4);
      chk_ra1 = 4'($urandom());
      chk_ra2 = 4'($urandom());
      chk_vs  = 1'($urandom());
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
